// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset multicycle controller:
// opcodes, FSM states, ALUOp and trap-cause codes, and the strobe bundle.
package riscv_ctrl_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned CAUSE_W = 2;

  localparam logic [OPC_W-1:0] R_TYPE = 7'b0110011;
  localparam logic [OPC_W-1:0] LW     = 7'b0000011;
  localparam logic [OPC_W-1:0] SW     = 7'b0100011;
  localparam logic [OPC_W-1:0] BR     = 7'b1100011;
  localparam logic [OPC_W-1:0] I_ALU  = 7'b0010011;

  localparam logic [ALUOP_W-1:0] ALUOP_I   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALUOP_BR  = 3'b001;
  localparam logic [ALUOP_W-1:0] ALUOP_R   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALUOP_MEM = 3'b100;

  localparam logic [CAUSE_W-1:0] CAUSE_NONE    = 2'b00;
  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [CAUSE_W-1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_e;

  // Control strobes produced each cycle for the datapath and memories
  typedef struct packed {
    logic               imem_req;
    logic               dmem_req;
    logic               ir_write;
    logic               pc_write;
    logic               alu_src;
    logic               mem_to_reg;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
  } ctrl_s;

  function automatic logic is_legal(input logic [OPC_W-1:0] opc);
    return (opc == R_TYPE) || (opc == LW) || (opc == SW) ||
           (opc == BR) || (opc == I_ALU);
  endfunction

  function automatic logic [ALUOP_W-1:0] alu_op_of(input logic [OPC_W-1:0] opc);
    logic [ALUOP_W-1:0] v;
    v = ALUOP_I;
    if (opc == R_TYPE)                 v = ALUOP_R;
    else if (opc == BR)                v = ALUOP_BR;
    else if (opc == LW || opc == SW)   v = ALUOP_MEM;
    return v;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle: run/opcode/ready inputs and the control strobes.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import riscv_ctrl_pkg::*;

  logic                 run;
  logic [OPC_W-1:0]     Opcode;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 imem_req;
  logic                 dmem_req;
  logic                 IRWrite;
  logic                 PCWrite;
  logic                 ALUSrc;
  logic                 MemtoReg;
  logic                 RegWrite;
  logic                 MemRead;
  logic                 MemWrite;
  logic [ALUOP_W-1:0]   ALUOp;
  logic                 Branch;
  logic                 trap;
  logic [CAUSE_W-1:0]   trap_cause;
  logic [CNT_W-1:0]     retired;

  modport master (
    input  run, Opcode, imem_ready, dmem_ready,
    output imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, ALUOp, Branch, trap, trap_cause, retired
  );

  modport slave (
    output run, Opcode, imem_ready, dmem_ready,
    input  imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, ALUOp, Branch, trap, trap_cause, retired
  );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory wait and flags a timeout
// on the last allowed cycle; WAIT_MAX = 0 disables the timeout.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int unsigned CW   = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam bit          EN   = (WAIT_MAX != 0);
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] r_cnt;

  // Cleared outside a wait and whenever the wait completes, so every entry starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_cnt <= '0;
    else if (!i_active || i_ready) r_cnt <= '0;
    else                          r_cnt <= r_cnt + CW'(1);
  end

  assign o_timeout = EN && i_active && !i_ready && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencing controller for the RV32I-subset datapath
// (add/and, addi/slti/slli/srai, lw, sw, beq) with trap and retire counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_e             r_state;
  state_e             w_state_next;
  logic [OPC_W-1:0]   r_op;
  logic               r_trap;
  logic [CAUSE_W-1:0] r_cause;
  logic [CNT_W-1:0]   r_retired;
  ctrl_s              w_ctrl;
  logic               w_wait_active;
  logic               w_wait_ready;
  logic               w_timeout;
  state_e             w_done_next;

  assign w_wait_active = (r_state == FETCH) || (r_state == MEM);
  assign w_wait_ready  = (r_state == FETCH) ? bus.imem_ready : bus.dmem_ready;
  // A finished instruction only starts another fetch while run is still high
  assign w_done_next   = bus.run ? FETCH : IDLE;

  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk       (clk),
    .rst       (reset),
    .i_active  (w_wait_active),
    .i_ready   (w_wait_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_ctrl       = '0;
    case (r_state)
      IDLE: begin
        if (bus.run) w_state_next = FETCH;
      end
      FETCH: begin
        w_ctrl.imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_state_next    = DECODE;
        end else if (w_timeout) begin
          w_state_next = TRAP;
        end
      end
      DECODE: begin
        w_state_next = is_legal(bus.Opcode) ? EXEC : TRAP;
      end
      EXEC: begin
        w_ctrl.alu_op  = alu_op_of(r_op);
        w_ctrl.alu_src = (r_op == LW) || (r_op == SW) || (r_op == I_ALU);
        if (r_op == BR) begin
          w_ctrl.branch   = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_state_next    = w_done_next;
        end else if (r_op == R_TYPE || r_op == I_ALU) begin
          w_state_next = WB;
        end else begin
          w_state_next = MEM;
        end
      end
      MEM: begin
        w_ctrl.dmem_req  = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_op    = ALUOP_MEM;
        w_ctrl.mem_read  = (r_op == LW);
        w_ctrl.mem_write = (r_op == SW);
        if (bus.dmem_ready) begin
          if (r_op == LW) begin
            w_state_next = WB;
          end else begin
            w_ctrl.pc_write = 1'b1;
            w_state_next    = w_done_next;
          end
        end else if (w_timeout) begin
          w_state_next = TRAP;
        end
      end
      WB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.pc_write   = 1'b1;
        w_ctrl.mem_to_reg = (r_op == LW);
        w_state_next      = w_done_next;
      end
      TRAP: begin
        w_state_next = TRAP;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Opcode latch, sticky trap cause and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= '0;
      r_trap    <= 1'b0;
      r_cause   <= CAUSE_NONE;
      r_retired <= '0;
    end else begin
      if (r_state == DECODE) r_op <= bus.Opcode;
      if (w_state_next == TRAP && r_state != TRAP) begin
        r_trap  <= 1'b1;
        r_cause <= (r_state == DECODE) ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
      end
      if (w_ctrl.pc_write) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign bus.imem_req   = w_ctrl.imem_req;
  assign bus.dmem_req   = w_ctrl.dmem_req;
  assign bus.IRWrite    = w_ctrl.ir_write;
  assign bus.PCWrite    = w_ctrl.pc_write;
  assign bus.ALUSrc     = w_ctrl.alu_src;
  assign bus.MemtoReg   = w_ctrl.mem_to_reg;
  assign bus.RegWrite   = w_ctrl.reg_write;
  assign bus.MemRead    = w_ctrl.mem_read;
  assign bus.MemWrite   = w_ctrl.mem_write;
  assign bus.ALUOp      = w_ctrl.alu_op;
  assign bus.Branch     = w_ctrl.branch;
  assign bus.trap       = r_trap;
  assign bus.trap_cause = r_cause;
  assign bus.retired    = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl (WAIT_MAX = 4): per-cycle strobe vectors,
// trap behaviour, retire counting and asynchronous reset.
module tb_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.WAIT_MAX(4), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Bit order: imem_req dmem_req IRWrite PCWrite ALUSrc MemtoReg RegWrite MemRead MemWrite ALUOp[2:0] Branch
  localparam logic [12:0] S_NONE        = 13'b0_0_0_0_0_0_0_0_0_000_0;
  localparam logic [12:0] S_FETCH       = 13'b1_0_1_0_0_0_0_0_0_000_0;
  localparam logic [12:0] S_FETCH_WAIT  = 13'b1_0_0_0_0_0_0_0_0_000_0;
  localparam logic [12:0] S_EXEC_R      = 13'b0_0_0_0_0_0_0_0_0_010_0;
  localparam logic [12:0] S_EXEC_I      = 13'b0_0_0_0_1_0_0_0_0_000_0;
  localparam logic [12:0] S_EXEC_MEM    = 13'b0_0_0_0_1_0_0_0_0_100_0;
  localparam logic [12:0] S_EXEC_BR     = 13'b0_0_0_1_0_0_0_0_0_001_1;
  localparam logic [12:0] S_WB_ALU      = 13'b0_0_0_1_0_0_1_0_0_000_0;
  localparam logic [12:0] S_WB_LW       = 13'b0_0_0_1_0_1_1_0_0_000_0;
  localparam logic [12:0] S_MEM_LW      = 13'b0_1_0_0_1_0_0_1_0_100_0;
  localparam logic [12:0] S_MEM_SW      = 13'b0_1_0_0_1_0_0_0_1_100_0;
  localparam logic [12:0] S_MEM_SW_DONE = 13'b0_1_0_1_1_0_0_0_1_100_0;

  function automatic logic [12:0] strobes();
    return {bus.imem_req, bus.dmem_req, bus.IRWrite, bus.PCWrite, bus.ALUSrc,
            bus.MemtoReg, bus.RegWrite, bus.MemRead, bus.MemWrite, bus.ALUOp, bus.Branch};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input logic [12:0] exp);
    check(tag, 32'(strobes()), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset          = 1'b1;
    bus.run        = 1'b0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    #1;
    chk_s({tag, "_strobes"}, S_NONE);
    check({tag, "_retired"}, bus.retired, 32'd0);
    check({tag, "_trap"}, 32'({bus.trap, bus.trap_cause}), 32'd0);
    step();
    reset = 1'b0;
  endtask

  task automatic begin_insn(input logic [6:0] opc);
    bus.Opcode = opc;
    bus.run    = 1'b1;
    step();
  endtask

  initial begin
    reset      = 1'b1;
    bus.run    = 1'b0;
    bus.Opcode = '0;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;

    // R-type then I-ALU back to back, run dropped during the second WB
    do_reset("rst_r");
    chk_s("r_idle", S_NONE);
    begin_insn(R_TYPE);
    chk_s("r_fetch", S_FETCH);
    step(); chk_s("r_decode", S_NONE);
    step(); chk_s("r_exec", S_EXEC_R);
    step(); chk_s("r_wb", S_WB_ALU);
    check("r_ret_before", bus.retired, 32'd0);
    step(); chk_s("r_next_fetch", S_FETCH);
    check("r_ret", bus.retired, 32'd1);
    bus.Opcode = I_ALU;
    step(); chk_s("i_decode", S_NONE);
    step(); chk_s("i_exec", S_EXEC_I);
    step(); chk_s("i_wb", S_WB_ALU);
    bus.run = 1'b0;
    step(); chk_s("i_idle", S_NONE);
    check("i_ret", bus.retired, 32'd2);
    step(); chk_s("i_idle_hold", S_NONE);

    // lw with three wait cycles; ready on the last allowed cycle wins over timeout
    do_reset("rst_lw");
    bus.dmem_ready = 1'b0;
    begin_insn(LW);
    chk_s("lw_fetch", S_FETCH);
    step(); chk_s("lw_decode", S_NONE);
    step(); chk_s("lw_exec", S_EXEC_MEM);
    for (int i = 0; i < 3; i++) begin
      step(); chk_s("lw_mem_wait", S_MEM_LW);
    end
    step();
    bus.dmem_ready = 1'b1;
    #1;
    chk_s("lw_mem_ready", S_MEM_LW);
    step(); chk_s("lw_wb", S_WB_LW);
    bus.run = 1'b0;
    step(); chk_s("lw_idle", S_NONE);
    check("lw_ret", bus.retired, 32'd1);
    check("lw_no_trap", 32'(bus.trap), 32'd0);

    // beq: three cycles, then straight back to FETCH
    do_reset("rst_br");
    begin_insn(BR);
    chk_s("br_fetch", S_FETCH);
    step(); chk_s("br_decode", S_NONE);
    step(); chk_s("br_exec", S_EXEC_BR);
    step(); chk_s("br_next_fetch", S_FETCH);
    check("br_ret", bus.retired, 32'd1);

    // sw with zero wait: PCWrite in the MEM cycle
    do_reset("rst_sw");
    begin_insn(SW);
    chk_s("sw_fetch", S_FETCH);
    step(); chk_s("sw_decode", S_NONE);
    step(); chk_s("sw_exec", S_EXEC_MEM);
    step(); chk_s("sw_mem", S_MEM_SW_DONE);
    step(); chk_s("sw_next_fetch", S_FETCH);
    check("sw_ret", bus.retired, 32'd1);

    // Illegal opcode traps after DECODE and stays there
    do_reset("rst_ill");
    begin_insn(7'b1111111);
    chk_s("ill_fetch", S_FETCH);
    step(); check("ill_decode_trap", 32'(bus.trap), 32'd0);
    step(); chk_s("ill_trap_strobes", S_NONE);
    check("ill_trap", 32'({bus.trap, bus.trap_cause}), 32'b1_01);
    check("ill_ret", bus.retired, 32'd0);
    step(); step();
    chk_s("ill_trap_hold", S_NONE);
    check("ill_trap_sticky", 32'({bus.trap, bus.trap_cause}), 32'b1_01);
    reset = 1'b1;
    #1;
    check("ill_async_clear", 32'({bus.trap, bus.trap_cause}), 32'd0);

    // Fetch timeout after four not-ready cycles
    do_reset("rst_to");
    bus.imem_ready = 1'b0;
    begin_insn(R_TYPE);
    for (int i = 0; i < 4; i++) begin
      chk_s("to_fetch_wait", S_FETCH_WAIT);
      step();
    end
    chk_s("to_trap_strobes", S_NONE);
    check("to_trap", 32'({bus.trap, bus.trap_cause}), 32'b1_10);
    check("to_ret", bus.retired, 32'd0);

    // Ready on the fourth fetch cycle avoids the trap
    do_reset("rst_to2");
    bus.imem_ready = 1'b0;
    begin_insn(R_TYPE);
    for (int i = 0; i < 3; i++) begin
      chk_s("to2_fetch_wait", S_FETCH_WAIT);
      step();
    end
    bus.imem_ready = 1'b1;
    #1;
    chk_s("to2_fetch_ready", S_FETCH);
    step(); chk_s("to2_decode", S_NONE);
    check("to2_no_trap", 32'(bus.trap), 32'd0);
    step(); chk_s("to2_exec", S_EXEC_R);

    // sw interrupted by reset during MEM: strobes drop without a clock edge
    do_reset("rst_swr");
    bus.dmem_ready = 1'b0;
    begin_insn(SW);
    step(); step(); step();
    chk_s("swr_mem", S_MEM_SW);
    reset = 1'b1;
    #1;
    chk_s("swr_async_drop", S_NONE);
    check("swr_ret", bus.retired, 32'd0);
    step();
    chk_s("swr_held", S_NONE);
    check("swr_ret_held", bus.retired, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle sequencing controller for the RV32I subset datapath: R-type add/and, I-ALU (addi/slti/slli/srai), lw, sw, beq.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes instruction and data memory with req/ready pairs and drives the same control strobes the datapath already consumes (ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, ALUOp, Branch) plus PCWrite/IRWrite.
- Traps on an illegal opcode or a memory timeout, and counts retired instructions.

Parameters:
- WAIT_MAX, 16: maximum cycles in a memory wait before a timeout trap. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  leave IDLE and begin fetching
- Opcode  in  7  instruction[6:0] from the IR; sampled in DECODE only
- imem_ready  in  1  instruction memory has data this cycle
- dmem_ready  in  1  data memory access completes this cycle
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- IRWrite  out  1  load the IR
- PCWrite  out  1  update the PC (PC+4, or branch target when Branch and zero)
- ALUSrc  out  1  0 = rs2, 1 = immediate
- MemtoReg  out  1  write-back from memory
- RegWrite  out  1  register file write enable
- MemRead  out  1  data read strobe
- MemWrite  out  1  data write strobe
- ALUOp  out  3  bit0 beq, bit1 R-type, bit2 lw/sw, 000 I-ALU
- Branch  out  1  beq evaluation cycle
- trap  out  1  sticky fault flag
- trap_cause  out  2  01 illegal opcode, 10 timeout
- retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (async): state = IDLE, op_q = 0, wait_cnt = 0, retired = 0, trap = 0, trap_cause = 00. All strobes are 0 and ALUOp = 000.
- All outputs are Moore functions of (state, op_q). The Opcode input never reaches an output combinationally.
- Latched opcode classes: R = 0110011, LW = 0000011, SW = 0100011, BR = 1100011, I = 0010011. Any other value is illegal.
- IDLE: if run = 1, go to FETCH next cycle. Otherwise stay.
- FETCH:
  - imem_req = 1.
  - If imem_ready = 1: IRWrite = 1 this cycle, go to DECODE.
  - Otherwise remain in FETCH.
- DECODE:
  - op_q <= Opcode.
  - Legal opcode: go to EXEC.
  - Illegal opcode: go to TRAP, trap_cause <= 01.
  - No strobes asserted.
- EXEC:
  - ALUSrc = 1 for LW/SW/I. ALUOp encodes op_q.
  - BR: Branch = 1 and PCWrite = 1 in this cycle, then go to FETCH (3-cycle beq).
  - R or I: go to WB.
  - LW or SW: go to MEM.
- MEM:
  - dmem_req = 1, ALUSrc = 1, ALUOp = 100. MemRead = 1 for LW, MemWrite = 1 for SW.
  - Strobes stay held until dmem_ready.
  - On ready, LW goes to WB. SW asserts PCWrite = 1 this cycle and goes to FETCH.
- WB:
  - RegWrite = 1, PCWrite = 1. MemtoReg = 1 for LW only.
  - Go to FETCH.
- Latencies with zero wait: R/I = 4 cycles, lw = 5, sw = 4, beq = 3.
- retired increments by 1 on every cycle with PCWrite = 1 and wraps modulo 2^CNT_W.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM and increments each cycle with ready = 0.
  - If WAIT_MAX > 0, ready = 0, and wait_cnt == WAIT_MAX - 1: go to TRAP, trap_cause <= 10.
  - If ready arrives on that same cycle, ready wins.
- TRAP: trap = 1, all strobes 0, and retired frozen. Only reset exits TRAP.
- Reset asserted mid-instruction: immediate return to IDLE. Strobes deassert without waiting for a clock edge. No partial retire is counted.
- run = 0 while an instruction is in flight has no effect. The controller finishes the instruction, then enters IDLE at the next FETCH boundary.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (R_TYPE, LW, SW, BR, I_ALU);
  - the state enum typedef (IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - the ALUOp encodings;
  - the trap_cause encodings.
- One sub-module, mem_wait_timer: wait counter plus timeout flag, parameterised by WAIT_MAX and instantiated once.

Test Plan:
- reset, run = 1, Opcode = 0110011, both readies tied 1 -> FETCH/DECODE/EXEC/WB, RegWrite pulses in cycle 4, ALUOp = 010, retired = 1.
- lw (0000011) with dmem_ready low for 3 cycles -> MemRead and dmem_req held 4 cycles, then WB with MemtoReg = 1 and RegWrite = 1, total 8 cycles, retired = 1.
- beq (1100011) -> Branch = 1 and PCWrite = 1 in cycle 3, ALUOp = 001, RegWrite never asserted, next cycle is FETCH.
- Opcode = 1111111 in DECODE -> trap = 1 and trap_cause = 01 next cycle, no further strobes, retired unchanged; reset clears everything.
- WAIT_MAX = 4, imem_ready held 0 -> TRAP with trap_cause = 10 after 4 FETCH cycles. Repeat with ready on the 4th cycle -> no trap.
- sw with reset asserted during MEM -> MemWrite drops asynchronously, state = IDLE, retired = 0.
